// File: rtl/fft_pkg.sv
// fft_pkg
// Shared types and index helpers for the radix-2 FFT address generator.
//   agu_state_e : frame state (IDLE, LOAD, PROC, OUT)
//   bitrev      : reverse the low nbits of a value
//   rotl        : rotate left within an nbits-wide field
//   tw_keep     : mask selecting the j bits that form the twiddle index
// Helpers work in a MAX_LOG2N-wide container so one set of functions
// serves every legal transform size; callers size-cast in and out.
package fft_pkg;

  localparam int MAX_LOG2N = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PROC = 2'd2,
    ST_OUT  = 2'd3
  } agu_state_e;

  // Reverse the whole container, then slide the reversed field back down.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int nbits);
    logic [MAX_LOG2N-1:0] rev;
    rev = {<<{value}};
    return rev >> (MAX_LOG2N - nbits);
  endfunction

  // amount must be below nbits; amount 0 leaves the value unchanged
  // because v >> nbits is zero for an nbits-wide value.
  function automatic logic [MAX_LOG2N-1:0] rotl(input logic [MAX_LOG2N-1:0] value,
                                                input int amount,
                                                input int nbits);
    logic [MAX_LOG2N-1:0] mask;
    logic [MAX_LOG2N-1:0] v;
    mask = {MAX_LOG2N{1'b1}} >> (MAX_LOG2N - nbits);
    v    = value & mask;
    return ((v << amount) | (v >> (nbits - amount))) & mask;
  endfunction

  // j is nbits-1 wide; its low (nbits-1-level) bits are dropped, so at
  // level 0 nothing survives and at the last level all of j survives.
  function automatic logic [MAX_LOG2N-1:0] tw_keep(input int level, input int nbits);
    logic [MAX_LOG2N-1:0] low;
    logic [MAX_LOG2N-1:0] jmask;
    low   = {MAX_LOG2N{1'b1}} >> (MAX_LOG2N - (nbits - 1 - level));
    jmask = {MAX_LOG2N{1'b1}} >> (MAX_LOG2N - (nbits - 1));
    return jmask & ~low;
  endfunction

endpackage

// File: rtl/fft_agu_seq_if.sv
// fft_agu_seq_if
// Bundle between the FFT address generator and its surroundings.
//   master : the address generator (consumes start/in_valid/out_ready,
//            drives state flags, load/read/write/output addressing)
//   slave  : the frame controller / datapath side
// LOG2N must match the LOG2N of the attached fft_agu_seq.
interface fft_agu_seq_if #(
  parameter int LOG2N = 6
);
  localparam int LVL_W = $clog2(LOG2N);

  logic             start;
  logic             in_valid;
  logic             out_ready;

  logic             load;
  logic             processing;
  logic             done;

  logic             load_we;
  logic [LOG2N-1:0] load_addr;

  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic             rd_bank;
  logic [LOG2N-2:0] twiddle_addr;
  logic [LVL_W-1:0] fft_level;

  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             wr_bank;

  logic             out_valid;
  logic [LOG2N-1:0] out_addr;
  logic             out_bank;

  modport master (
    input  start, in_valid, out_ready,
    output load, processing, done, load_we, load_addr,
    output rd_en, rd_addr_a, rd_addr_b, rd_bank, twiddle_addr, fft_level,
    output wr_en, wr_addr_a, wr_addr_b, wr_bank,
    output out_valid, out_addr, out_bank
  );

  modport slave (
    output start, in_valid, out_ready,
    input  load, processing, done, load_we, load_addr,
    input  rd_en, rd_addr_a, rd_addr_b, rd_bank, twiddle_addr, fft_level,
    input  wr_en, wr_addr_a, wr_addr_b, wr_bank,
    input  out_valid, out_addr, out_bank
  );

endinterface

// File: rtl/fft_agu_seq_write_pipe.sv
// agu_write_pipe
// Fixed-depth delay line with a per-stage valid bit, used to hold read
// addresses until the butterfly result they belong to is ready.
//   clk, reset : clock and synchronous active-high reset (clears all stages)
//   in_valid   : stage-0 valid
//   in_data    : stage-0 payload (WIDTH bits)
//   out_valid  : valid leaving the last stage, DEPTH cycles later
//   out_data   : payload leaving the last stage
module agu_write_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             valid_next;
      logic [WIDTH-1:0] data_next;

      if (gi == 0) begin : g_head
        assign valid_next = in_valid;
        assign data_next  = in_data;
      end else begin : g_body
        assign valid_next = g_stage[gi-1].valid_reg;
        assign data_next  = g_stage[gi-1].data_reg;
      end

      // Payload is cleared too so write addresses read as zero after reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_next;
          data_reg  <= data_next;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].valid_reg;
  assign out_data  = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/fft_agu_seq.sv
// fft_agu_seq
// Self-sequencing address generator for an in-place radix-2 FFT.
// A frame runs IDLE -> LOAD (bit-reversed sample writes into bank 0)
// -> PROC (LOG2N levels, each N/2 butterfly reads then BFLY_LAT drain
// cycles) -> OUT (natural-order readout) -> IDLE.
//   clk   : sole clock
//   reset : synchronous, active-high
//   bus   : fft_agu_seq_if.master -- start/in_valid/out_ready in;
//           state flags, load, read, twiddle, write-back and output
//           addressing out. Read-side outputs are combinational from
//           registered state; write-back outputs are the read side
//           delayed by BFLY_LAT cycles with the bank inverted.
module fft_agu_seq
  import fft_pkg::*;
#(
  parameter int LOG2N    = 6,
  parameter int BFLY_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  fft_agu_seq_if.master bus
);

  localparam int N      = 1 << LOG2N;
  localparam int HALF   = N / 2;
  localparam int LVL_W  = $clog2(LOG2N);
  localparam int J_W    = LOG2N - 1;
  localparam int DC_W   = $clog2(BFLY_LAT + 1);
  localparam int PIPE_W = 2 * LOG2N + 1;

  agu_state_e       state_reg, state_next;
  logic [LOG2N-1:0] count_reg, count_next;   // load count, then output count
  logic [J_W-1:0]   j_reg, j_next;           // butterfly index within a level
  logic [LVL_W-1:0] level_reg, level_next;
  logic             drain_reg, drain_next;   // PROC sub-phase: 0 ISSUE, 1 DRAIN
  logic [DC_W-1:0]  dcnt_reg, dcnt_next;

  logic flag_load, flag_proc, flag_out, rd_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      j_reg     <= '0;
      level_reg <= '0;
      drain_reg <= 1'b0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      j_reg     <= j_next;
      level_reg <= level_next;
      drain_reg <= drain_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    j_next     = j_reg;
    level_next = level_reg;
    drain_next = drain_reg;
    dcnt_next  = dcnt_reg;
    flag_load  = 1'b0;
    flag_proc  = 1'b0;
    flag_out   = 1'b0;
    rd_issue   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_LOAD;
          count_next = '0;
        end
      end

      ST_LOAD: begin
        flag_load = 1'b1;
        if (bus.in_valid) begin
          count_next = count_reg + 1'b1;
          if (count_reg == LOG2N'(N - 1)) begin
            state_next = ST_PROC;
            level_next = '0;
            j_next     = '0;
            drain_next = 1'b0;
            dcnt_next  = '0;
          end
        end
      end

      ST_PROC: begin
        flag_proc = 1'b1;
        if (!drain_reg) begin
          rd_issue = 1'b1;
          j_next   = j_reg + 1'b1;
          if (j_reg == J_W'(HALF - 1)) begin
            drain_next = 1'b1;
            dcnt_next  = '0;
          end
        end else begin
          // The last write of this level lands on the last drain cycle, so
          // the next level's first read can never see stale data.
          dcnt_next = dcnt_reg + 1'b1;
          if (dcnt_reg == DC_W'(BFLY_LAT - 1)) begin
            drain_next = 1'b0;
            j_next     = '0;
            if (level_reg == LVL_W'(LOG2N - 1)) begin
              state_next = ST_OUT;
              count_next = '0;
            end else begin
              level_next = level_reg + 1'b1;
            end
          end
        end
      end

      ST_OUT: begin
        flag_out = 1'b1;
        if (bus.out_ready) begin
          count_next = count_reg + 1'b1;
          if (count_reg == LOG2N'(N - 1)) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Address arithmetic in the package's full-width container.
  logic [MAX_LOG2N-1:0] rev_full, rot_a_full, rot_b_full, tw_full;

  assign rev_full   = bitrev(MAX_LOG2N'(count_reg), LOG2N);
  assign rot_a_full = rotl(MAX_LOG2N'({j_reg, 1'b0}), 32'(level_reg), LOG2N);
  assign rot_b_full = rotl(MAX_LOG2N'({j_reg, 1'b1}), 32'(level_reg), LOG2N);
  assign tw_full    = MAX_LOG2N'(j_reg) & tw_keep(32'(level_reg), LOG2N);

  logic [LOG2N-1:0] rd_a, rd_b;
  logic             rd_bank_c;

  // Addresses are forced to zero outside their phase so idle buses are quiet.
  assign rd_a      = rd_issue ? LOG2N'(rot_a_full) : '0;
  assign rd_b      = rd_issue ? LOG2N'(rot_b_full) : '0;
  assign rd_bank_c = flag_proc & level_reg[0];

  assign bus.load         = flag_load;
  assign bus.processing   = flag_proc;
  assign bus.done         = flag_out;
  assign bus.load_we      = flag_load & bus.in_valid;
  assign bus.load_addr    = flag_load ? LOG2N'(rev_full) : '0;
  assign bus.rd_en        = rd_issue;
  assign bus.rd_addr_a    = rd_a;
  assign bus.rd_addr_b    = rd_b;
  assign bus.rd_bank      = rd_bank_c;
  assign bus.twiddle_addr = rd_issue ? J_W'(tw_full) : '0;
  assign bus.fft_level    = level_reg;
  assign bus.out_valid    = flag_out;
  assign bus.out_addr     = flag_out ? count_reg : '0;
  assign bus.out_bank     = 1'((LOG2N % 2) != 0);

  // Results go to the bank not being read; payload is zeroed on idle
  // slots so the write bus only carries data alongside wr_en.
  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic              pipe_valid;

  assign pipe_in = rd_issue ? {rd_a, rd_b, ~rd_bank_c} : '0;

  agu_write_pipe #(
    .WIDTH (PIPE_W),
    .DEPTH (BFLY_LAT)
  ) u_write_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_issue),
    .in_data   (pipe_in),
    .out_valid (pipe_valid),
    .out_data  (pipe_out)
  );

  assign bus.wr_en     = pipe_valid;
  assign bus.wr_addr_a = pipe_out[PIPE_W-1 -: LOG2N];
  assign bus.wr_addr_b = pipe_out[LOG2N -: LOG2N];
  assign bus.wr_bank   = pipe_out[0];

endmodule

// File: doc/fft_agu_seq.md
# fft_agu_seq

Self-sequencing, parametrised address generation unit for the in-place radix-2 FFT datapath. It owns the frame state machine: LOAD (bit-reversed sample writes), PROC (all butterfly levels), then OUT (natural-order readout). It also owns the iteration counters, level counter, and ping-pong bank selection. Write-back addresses are delayed to match the butterfly pipeline latency. It sits between the sample front-end, the two data RAMs, the twiddle ROM and the butterfly unit, and replaces externally driven level/iteration counters.

## Interface
Parameters:
- LOG2N, 6, log2 of FFT points; N = 2**LOG2N; legal range 2..10.
- BFLY_LAT, 2, cycles from read address issue to butterfly result ready for write-back; legal ≥1.

Ports (LVL_W = $clog2(LOG2N)):
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- in_valid  in  1  input sample present; honoured only in LOAD.
- out_ready  in  1  consumer accepts current output sample; honoured only in OUT.
- load, processing, done  out  1 each  one-hot state flags (LOAD, PROC, OUT).
- load_we  out  1  write the input sample this cycle (= load & in_valid).
- load_addr  out  LOG2N  bit-reversed load count.
- rd_en  out  1  butterfly read issued this cycle.
- rd_addr_a, rd_addr_b  out  LOG2N  butterfly operand addresses.
- rd_bank  out  1  RAM read this level.
- twiddle_addr  out  LOG2N-1  twiddle ROM index.
- fft_level  out  LVL_W  current level.
- wr_en  out  1  write butterfly results.
- wr_addr_a, wr_addr_b  out  LOG2N  write-back addresses.
- wr_bank  out  1  RAM written.
- out_valid  out  1  output sample address valid.
- out_addr  out  LOG2N  natural-order index.
- out_bank  out  1  bank holding the result, constant LOG2N%2.

## Operation
- States: IDLE, LOAD, PROC, OUT. The state register and counters are the only state, apart from the write pipe.
- IDLE:
  - start=1 → LOAD; the load count is cleared.
- LOAD:
  - Each cycle with in_valid=1: load_we=1, load_addr=bitrev(count), count++. Writes go to bank 0.
  - With in_valid=0 the count holds.
  - After the N-th accepted sample → PROC, with level=0, j=0.
- PROC has two sub-phases, ISSUE and DRAIN.
- ISSUE: one butterfly per cycle, j = 0..N/2-1.
  - rd_en=1.
  - rd_addr_a = rotl(2j, level); rd_addr_b = rotl(2j+1, level). Rotation is over LOG2N bits.
  - twiddle_addr = j with its low (LOG2N-1-level) bits zeroed, so only the top `level` bits of j are kept. At level 0 it is 0.
  - rd_bank = level[0].
- DRAIN: BFLY_LAT cycles after j=N/2-1, with rd_en=0. This avoids a read-after-write hazard across levels.
- End of DRAIN:
  - If level < LOG2N-1: level++, j=0, back to ISSUE.
  - Otherwise → OUT.
- Write pipe:
  - A BFLY_LAT-deep delay line carries {rd_en, rd_addr_a, rd_addr_b, ~rd_bank}.
  - Its tail drives {wr_en, wr_addr_a, wr_addr_b, wr_bank}.
- OUT:
  - out_valid=1, out_addr=count starting at 0.
  - count++ on out_ready.
  - After the N-th accepted sample → IDLE.
- Ignored inputs: start outside IDLE; in_valid outside LOAD; out_ready outside OUT.

## Timing
- Reset values: state IDLE; all counters, level, out_addr, load_addr and rd/wr addresses are 0; all flags and enables are 0; write-pipe valid bits are cleared.
- Reset mid-operation: the next cycle is IDLE with wr_en=0. In-flight writes are discarded.
- Flags, rd_* and twiddle_addr are combinational from registered state; they are valid in the same cycle as the state.
- wr_* equals the rd_* of exactly BFLY_LAT cycles earlier.
- The last write of a level occurs on the last DRAIN cycle. The first read of the next level follows on the next cycle.
- Cycle counts:
  - LOAD lasts N cycles with in_valid held high.
  - PROC lasts LOG2N·(N/2+BFLY_LAT) cycles; 204 for the defaults.
  - OUT lasts N cycles with out_ready held high.
- A start pulse in the same cycle as the OUT→IDLE transition is not honoured. start must arrive in IDLE.

## Structure
- Package fft_pkg:
  - state enum typedef.
  - functions bitrev(LOG2N) and rotl(value, amount, LOG2N).
  - twiddle mask function.
- Sub-module agu_write_pipe (parameters WIDTH, DEPTH=BFLY_LAT): synchronous-reset delay line with a valid bit, instantiated once.

## Test plan
1. Reset, start, then in_valid high for 64 cycles → load_addr = 0, 32, 16, 48, 8, …; load high for exactly 64 cycles, then processing=1, fft_level=0.
2. in_valid alternating 1/0 → load_we only on valid cycles; load_addr holds during gaps; 64 writes total, then PROC.
3. Level 1, j=5 → rd_addr 20/22, twiddle 0, rd_bank 1. Level 2, j=20 → twiddle 16. Level 5, j=5 → rd_addr 5/37, twiddle 5.
4. Write pipe and drain:
   - Every wr_en matches the rd_addr and inverted bank from 2 cycles earlier.
   - 2 cycles with rd_en=0 occur between levels.
   - processing lasts 204 cycles with 192 wr_en pulses.
5. OUT with out_ready toggling → out_addr steps 0..63 only on ready; out_bank=0; then IDLE with all flags 0.
6. Reset and start:
   - reset asserted at level 3 → next cycle IDLE, wr_en=0, fft_level=0.
   - start during PROC → no effect.
